// File: rtl/audio_out_feeder_if.sv
// Sample ingress and codec egress handshakes of the audio output feeder.
// master = feeder side; slave = tone generator plus codec side.
interface audio_out_feeder_if;
    logic [31:0] sound_in;
    logic        sound_valid;
    logic        sound_ready;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;

    modport master (
        input  sound_in, sound_valid, audio_out_allowed,
        output sound_ready, write_audio_out,
        output left_channel_audio_out, right_channel_audio_out
    );

    modport slave (
        output sound_in, sound_valid, audio_out_allowed,
        input  sound_ready, write_audio_out,
        input  left_channel_audio_out, right_channel_audio_out
    );
endinterface

// File: rtl/audio_out_feeder.sv
// Buffers tone samples, attenuates/mutes them and strobes them into both codec channels.
// Latency 1 cycle from pop to strobe; sound_ready drops when full, codec stalls via audio_out_allowed.
module audio_out_feeder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int PRIME = 4
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    audio_out_feeder_if.master  aud,
    input  logic [2:0]          volume,
    input  logic                mute,
    output logic [AW:0]         fifo_level,
    output logic [15:0]         underrun_count,
    output logic                overflow
);
    typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, STARVED = 2'd2} state_t;

    localparam logic [AW:0] LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_PRIME = (AW+1)'(PRIME);

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push;
    logic               pop;
    logic signed [31:0] rd_sample;
    logic [31:0]        out_sample;

    assign aud.sound_ready = (fifo_level != LVL_FULL);
    assign push = aud.sound_valid && aud.sound_ready;
    // The strobe term forces an idle cycle between codec writes.
    assign pop  = (state == RUN) && aud.audio_out_allowed &&
                  (fifo_level != '0) && !aud.write_audio_out;

    assign rd_sample  = mem[rd_ptr];
    assign out_sample = mute ? 32'd0 : 32'(rd_sample >>> volume);

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem[wr_ptr] <= aud.sound_in;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (fifo_level >= LVL_PRIME) state_nxt = RUN;
            RUN:     if (aud.audio_out_allowed && (fifo_level == '0) && !aud.write_audio_out)
                         state_nxt = STARVED;
            STARVED: state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr                      <= '0;
            rd_ptr                      <= '0;
            fifo_level                  <= '0;
            overflow                    <= 1'b0;
            underrun_count              <= '0;
            aud.write_audio_out         <= 1'b0;
            aud.left_channel_audio_out  <= '0;
            aud.right_channel_audio_out <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (aud.sound_valid && !aud.sound_ready) overflow <= 1'b1;
            // One count per episode: STARVED is only entered from RUN.
            if ((state_nxt == STARVED) && (state != STARVED) && (underrun_count != 16'hFFFF))
                underrun_count <= underrun_count + 16'd1;
            aud.write_audio_out <= pop;
            if (pop) begin
                aud.left_channel_audio_out  <= out_sample;
                aud.right_channel_audio_out <= out_sample;
            end
        end
    end
endmodule

// File: tb/tb_audio_out_feeder.sv
// Directed bench for audio_out_feeder with an expected-sample scoreboard on the codec side.
module tb_audio_out_feeder;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  volume;
    logic        mute;
    logic [3:0]  fifo_level;
    logic [15:0] underrun_count;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    logic        prev_wr = 1'b0;

    audio_out_feeder_if bus ();

    audio_out_feeder #(.DEPTH(8), .AW(3), .PRIME(4)) dut (
        .CLOCK_50       (clk),
        .reset          (reset),
        .aud            (bus.master),
        .volume         (volume),
        .mute           (mute),
        .fifo_level     (fifo_level),
        .underrun_count (underrun_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [31:0] d, input logic [31:0] e, input bit acc);
        bus.sound_valid = 1'b1;
        bus.sound_in    = d;
        if (acc) exp_q.push_back(e);
        tick();
        bus.sound_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Codec-side scoreboard: every strobe must match the oldest expected sample.
    always @(negedge clk) begin
        if (bus.write_audio_out === 1'b1) begin
            chk("strobe_gap", {31'd0, prev_wr}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", bus.left_channel_audio_out, 32'hDEAD_BEEF);
            end else begin
                chk("left",  bus.left_channel_audio_out,  exp_q[0]);
                chk("right", bus.right_channel_audio_out, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
        prev_wr = (bus.write_audio_out === 1'b1);
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; volume = 3'd0; mute = 1'b0;
        bus.sound_in = '0; bus.sound_valid = 1'b0; bus.audio_out_allowed = 1'b1;
        ticks(2);
        reset = 1'b0;
        chk("rst_level",    32'(fifo_level), 32'd0);
        chk("rst_wr",       32'(bus.write_audio_out), 32'd0);
        chk("rst_left",     bus.left_channel_audio_out, 32'd0);
        chk("rst_right",    bus.right_channel_audio_out, 32'd0);
        chk("rst_underrun", 32'(underrun_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_state",    32'(dut.state), 32'd0);
        chk("rst_ready",    32'(bus.sound_ready), 32'd1);

        // Priming: nothing leaves until four samples are queued.
        for (int i = 1; i <= 4; i++) begin
            push(32'(i), 32'(i), 1'b1);
            chk("no_early_write", 32'(bus.write_audio_out), 32'd0);
        end
        drain("drain_prime");
        ticks(6);
        chk("underrun_1", 32'(underrun_count), 32'd1);
        chk("state_fill_1", 32'(dut.state), 32'd0);

        // Overflow: only the first eight of ten survive.
        bus.audio_out_allowed = 1'b0;
        for (int i = 0; i < 10; i++) push(32'(100 + i), 32'(100 + i), i < 8);
        chk("full_level", 32'(fifo_level), 32'd8);
        chk("full_ready", 32'(bus.sound_ready), 32'd0);
        chk("overflow_set", 32'(overflow), 32'd1);
        bus.audio_out_allowed = 1'b1;
        drain("drain_overflow");
        ticks(6);
        chk("underrun_2", 32'(underrun_count), 32'd2);

        // Attenuation with sign preservation, then mute.
        volume = 3'd4;
        push(32'hFFFF_FF00, 32'hFFFF_FFF0, 1'b1);
        push(32'h0000_0100, 32'h0000_0010, 1'b1);
        push(32'h8000_0000, 32'hF800_0000, 1'b1);
        push(32'h7FFF_FFF0, 32'h07FF_FFFF, 1'b1);
        drain("drain_volume");
        ticks(6);
        chk("underrun_3", 32'(underrun_count), 32'd3);
        mute = 1'b1;
        push(32'hFFFF_FF00, 32'd0, 1'b1);
        push(32'h0000_0100, 32'd0, 1'b1);
        push(32'h8000_0000, 32'd0, 1'b1);
        push(32'h7FFF_FFF0, 32'd0, 1'b1);
        drain("drain_mute");
        ticks(6);
        chk("underrun_4", 32'(underrun_count), 32'd4);
        mute = 1'b0; volume = 3'd0;

        // Simultaneous push and pop at level 3, then a 20-sample wrap run.
        bus.audio_out_allowed = 1'b0;
        for (int i = 0; i < 4; i++) push(32'(400 + i), 32'(400 + i), 1'b1);
        ticks(2);
        chk("run_state", 32'(dut.state), 32'd1);
        chk("run_level", 32'(fifo_level), 32'd4);
        bus.audio_out_allowed = 1'b1;
        tick();
        chk("pop_level", 32'(fifo_level), 32'd3);
        tick();
        chk("gap_level", 32'(fifo_level), 32'd3);
        push(32'd500, 32'd500, 1'b1);
        chk("simul_level", 32'(fifo_level), 32'd3);
        for (int i = 0; i < 20; i++) begin
            push(32'(600 + i), 32'(600 + i), 1'b1);
            tick();
        end
        drain("drain_wrap");
        ticks(6);
        chk("underrun_5", 32'(underrun_count), 32'd5);
        chk("wrap_level", 32'(fifo_level), 32'd0);

        // Saturation of the underrun counter.
        force dut.underrun_count = 16'hFFFF;
        tick();
        release dut.underrun_count;
        for (int i = 0; i < 4; i++) push(32'(800 + i), 32'(800 + i), 1'b1);
        drain("drain_sat");
        ticks(6);
        chk("underrun_sat", 32'(underrun_count), 32'h0000_FFFF);
        chk("state_fill_sat", 32'(dut.state), 32'd0);

        // Reset in RUN with five queued and a write in flight.
        bus.audio_out_allowed = 1'b0;
        for (int i = 0; i < 5; i++) push(32'(700 + i), 32'(700 + i), 1'b1);
        ticks(2);
        chk("pre_rst_state", 32'(dut.state), 32'd1);
        chk("pre_rst_level", 32'(fifo_level), 32'd5);
        bus.audio_out_allowed = 1'b1;
        tick();
        chk("pre_rst_wr", 32'(bus.write_audio_out), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        chk("mid_rst_level",    32'(fifo_level), 32'd0);
        chk("mid_rst_wr",       32'(bus.write_audio_out), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_left",     bus.left_channel_audio_out, 32'd0);
        chk("mid_rst_right",    bus.right_channel_audio_out, 32'd0);
        chk("mid_rst_underrun", 32'(underrun_count), 32'd0);
        chk("mid_rst_state",    32'(dut.state), 32'd0);
        tick();
        chk("post_rst_wr", 32'(bus.write_audio_out), 32'd0);
        ticks(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
